branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  In-order queue of in-flight conditional-branch predictions, between fetch-side global predictor and execute.
//  Holds per-branch: hashed table index, predicted direction, recovery PC; pops on execute resolution.
//  Drives predictor table update (write / actual_outcome_idx / actual_outcome), mispredict redirect.
// PARAMETERS
//  IDX_W    10   width of hashed predictor index (matches predicted_outcome_idx)
//  DEPTH    4    queue entries; power of two, >= 2
//  PC_W     32   width of recovery PC
// PORTS
//  clk            in   1      clock; all state on rising edge
//  rst            in   1      asynchronous, active-low reset (rst==0 resets)
//  flush          in   1      pipeline flush (exception/trap); clears all entries
//  alloc          in   1      fetch pushes a predicted branch this cycle
//  alloc_idx      in   IDX_W  hashed index used for the prediction
//  alloc_pred     in   1      predicted direction (1 = taken)
//  alloc_alt_pc   in   PC_W   PC of path NOT predicted (recovery target)
//  alloc_ready    out  1      queue can accept alloc this cycle (combinational = !full)
//  resolve_valid  in   1      execute resolves oldest outstanding branch
//  resolve_taken  in   1      actual direction
//  upd_write      out  1      predictor update strobe (to predictor write)
//  upd_idx        out  IDX_W  index to update (to actual_outcome_idx)
//  upd_taken      out  1      actual outcome (to actual_outcome)
//  mispredict     out  1      one-cycle redirect pulse
//  redirect_pc    out  PC_W   PC fetch must restart from; valid when mispredict==1
//  count          out  $clog2(DEPTH)+1  occupied entries
//  underflow_err  out  1      sticky: resolve_valid seen while empty
// BEHAVIOUR
//  - Reset (rst==0, async): head/tail ptrs, count, all outputs = 0; entries contents don't-care.
//  - Circular buffer; ptrs $clog2(DEPTH)+1 bits, MSB distinguishes full from empty; wrap modulo DEPTH.
//  - Alloc accepted iff alloc && alloc_ready; write at tail, tail+1. alloc while full: dropped, no state change.
//  - Resolve consumes head iff resolve_valid && count!=0 (count taken before this cycle's alloc).
//  - resolve_valid && count==0: ignored, no update, underflow_err set; cleared only by reset.
//  - Outputs registered, latency 1: cycle after accepted resolve: upd_write=1, upd_idx=head.idx,
//    upd_taken=resolve_taken; mispredict=(resolve_taken!=head.pred), redirect_pc=head.alt_pc.
//    Otherwise upd_write=0, mispredict=0; upd_idx/upd_taken/redirect_pc hold last value.
//  - Mispredict in resolve cycle: all younger entries discarded (count->0, head=tail), same-cycle alloc dropped.
//  - Simultaneous alloc+resolve, no mispredict: both take effect, count unchanged; legal when full only
//    if alloc_ready was 1 (it is not when full -> alloc dropped).
//  - flush: queue emptied next edge, same-cycle alloc dropped. Same-cycle valid resolve still issues
//    upd_write (branch committed) but mispredict forced 0.
//  - count = tail - head, always 0..DEPTH; alloc_ready = (count != DEPTH).
//  - Reset asserted mid-operation: everything cleared immediately; no pending upd_write/mispredict survives.
// STRUCTURE
//  - bp_pkg: IDX_W/PC_W localparams, typedef bp_idx_t, struct bq_entry_t {bp_idx_t idx; logic pred; pc alt_pc}.
//  - Single module: entry array, ptr logic, registered output stage; no sub-module needed.
//  - Connects upd_* straight to predictor write/actual_outcome_idx/actual_outcome ports.
// TESTING
//  1 Reset, then alloc idx=0x155 pred=1 alt=0x100; resolve taken=1 -> next cycle upd_write=1,
//    upd_idx=0x155, upd_taken=1, mispredict=0, count=0.
//  2 Alloc 4 (DEPTH=4) -> alloc_ready=0, count=4; 5th alloc dropped; resolve 4 in order -> upd_idx matches
//    alloc order, ptrs wrap, count back to 0.
//  3 Alloc A(pred=0,alt=0x2000), B, C; resolve A taken=1 -> mispredict=1, redirect_pc=0x2000, count=0;
//    B,C never produce upd_write.
//  4 count=2, alloc+resolve same cycle, correct prediction -> count stays 2, one upd_write.
//  5 resolve_valid while empty -> no upd_write, underflow_err=1 and stays 1 until rst=0.
//  6 count=3, flush with resolve(mispredicting) same cycle -> upd_write=1, mispredict=0, count=0;
//    async rst low mid-burst -> all outputs 0 before next clk edge.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: predictor index, PC and queue entry.
package branch_resolve_queue_pkg;
  localparam int IDX_W = 10;
  localparam int PC_W  = 32;

  typedef logic [IDX_W-1:0] bp_idx_t;
  typedef logic [PC_W-1:0]  bp_pc_t;

  typedef struct packed {
    bp_idx_t idx;
    logic    pred;
    bp_pc_t  alt_pc;
  } bq_entry_t;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue.
interface branch_resolve_queue_if #(parameter int DEPTH = 4);
  import branch_resolve_queue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             alloc;
  bp_idx_t          alloc_idx;
  logic             alloc_pred;
  bp_pc_t           alloc_alt_pc;
  logic             alloc_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             upd_write;
  bp_idx_t          upd_idx;
  logic             upd_taken;
  logic             mispredict;
  bp_pc_t           redirect_pc;
  logic [CNT_W-1:0] count;
  logic             underflow_err;

  modport master (
    output flush, alloc, alloc_idx, alloc_pred, alloc_alt_pc, resolve_valid, resolve_taken,
    input  alloc_ready, upd_write, upd_idx, upd_taken, mispredict, redirect_pc, count, underflow_err
  );

  modport slave (
    input  flush, alloc, alloc_idx, alloc_pred, alloc_alt_pc, resolve_valid, resolve_taken,
    output alloc_ready, upd_write, upd_idx, upd_taken, mispredict, redirect_pc, count, underflow_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; pops on resolve, drives predictor
// update and mispredict redirect through a registered output stage.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  branch_resolve_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  bq_entry_t     mem [DEPTH];
  logic [PW-1:0] head, tail, cnt;
  bq_entry_t     head_e;
  logic          full, res_ok, mis, alloc_ok;

  // Extra pointer MSB separates full (cnt==DEPTH) from empty (cnt==0).
  assign cnt      = tail - head;
  assign full     = (cnt == PW'(DEPTH));
  assign head_e   = mem[head[AW-1:0]];
  assign res_ok   = bus.resolve_valid && (cnt != '0);
  assign mis      = res_ok && (bus.resolve_taken != head_e.pred) && !bus.flush;
  assign alloc_ok = bus.alloc && !full && !bus.flush && !mis;

  assign bus.alloc_ready = !full;
  assign bus.count       = cnt;

  always_ff @(posedge clk)
    if (alloc_ok)
      mem[tail[AW-1:0]] <= '{idx: bus.alloc_idx, pred: bus.alloc_pred, alt_pc: bus.alloc_alt_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head              <= '0;
      tail              <= '0;
      bus.upd_write     <= 1'b0;
      bus.upd_idx       <= '0;
      bus.upd_taken     <= 1'b0;
      bus.mispredict    <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      // Flush or mispredict discards every younger entry in one step.
      if (bus.flush || mis) head <= tail;
      else                  head <= head + PW'(res_ok);
      tail <= tail + PW'(alloc_ok);

      bus.upd_write  <= res_ok;
      bus.mispredict <= mis;
      if (res_ok) begin
        bus.upd_idx     <= head_e.idx;
        bus.upd_taken   <= bus.resolve_taken;
        bus.redirect_pc <= head_e.alt_pc;
      end
      if (bus.resolve_valid && cnt == '0) bus.underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH)) bus();
  branch_resolve_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of outstanding predictions.
  bq_entry_t mq[$];
  logic        e_upd_write = 0, e_upd_taken = 0, e_mis = 0, e_uf = 0;
  logic [9:0]  e_idx = 0;
  logic [31:0] e_pc = 0;
  int          m_n;
  bit          m_res, m_mis;
  bq_entry_t   m_h;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      e_upd_write = 0; e_upd_taken = 0; e_mis = 0; e_uf = 0; e_idx = 0; e_pc = 0;
    end else begin
      m_n   = mq.size();
      m_res = bus.resolve_valid && m_n > 0;
      m_mis = 0;
      e_upd_write = m_res;
      if (bus.resolve_valid && m_n == 0) e_uf = 1;
      if (m_res) begin
        m_h = mq.pop_front();
        e_idx = m_h.idx;
        e_upd_taken = bus.resolve_taken;
        e_pc = m_h.alt_pc;
        m_mis = (m_h.pred != bus.resolve_taken) && !bus.flush;
      end
      e_mis = m_mis;
      if (bus.flush || m_mis) mq.delete();
      else if (bus.alloc && m_n < DEPTH)
        mq.push_back('{idx: bus.alloc_idx, pred: bus.alloc_pred, alt_pc: bus.alloc_alt_pc});
    end
  end

  always @(negedge clk) begin
    chk("m_upd_write", 32'(bus.upd_write), 32'(e_upd_write));
    chk("m_mispredict", 32'(bus.mispredict), 32'(e_mis));
    chk("m_upd_idx", 32'(bus.upd_idx), 32'(e_idx));
    chk("m_upd_taken", 32'(bus.upd_taken), 32'(e_upd_taken));
    chk("m_redirect_pc", bus.redirect_pc, e_pc);
    chk("m_count", 32'(bus.count), 32'(mq.size()));
    chk("m_alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() < DEPTH));
    chk("m_underflow", 32'(bus.underflow_err), 32'(e_uf));
  end

  // Called at posedge+1; drives one cycle of inputs and returns at posedge+1 after it.
  task automatic step(input logic a, input logic [9:0] ix, input logic pr, input logic [31:0] alt,
                      input logic rv, input logic rt, input logic fl);
    bus.alloc = a; bus.alloc_idx = ix; bus.alloc_pred = pr; bus.alloc_alt_pc = alt;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.flush = fl;
    @(posedge clk); #1;
    bus.alloc = 0; bus.resolve_valid = 0; bus.resolve_taken = 0; bus.flush = 0;
  endtask

  initial begin
    bus.alloc = 0; bus.alloc_idx = 0; bus.alloc_pred = 0; bus.alloc_alt_pc = 0;
    bus.resolve_valid = 0; bus.resolve_taken = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upd_write", 32'(bus.upd_write), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_underflow", 32'(bus.underflow_err), 0);
    rst = 1;
    @(posedge clk); #1;

    // 1: single alloc then correct resolve
    step(1, 10'h155, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t1_upd_write", 32'(bus.upd_write), 1);
    chk("t1_upd_idx", 32'(bus.upd_idx), 32'h155);
    chk("t1_upd_taken", 32'(bus.upd_taken), 1);
    chk("t1_mispredict", 32'(bus.mispredict), 0);
    chk("t1_count", 32'(bus.count), 0);

    // 2: fill, drop 5th alloc, drain in order across the wrap
    for (int i = 0; i < 4; i++) step(1, 10'(32'h10 + i), 1'(i), 32'h1000 + i, 0, 0, 0);
    chk("t2_full_ready", 32'(bus.alloc_ready), 0);
    chk("t2_full_count", 32'(bus.count), 4);
    step(1, 10'h3ff, 0, 32'hdead, 0, 0, 0);
    chk("t2_drop_count", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1'(i), 0);
      chk("t2_order_idx", 32'(bus.upd_idx), 32'h10 + i);
      chk("t2_order_mis", 32'(bus.mispredict), 0);
    end
    chk("t2_empty_count", 32'(bus.count), 0);

    // 3: mispredict on oldest discards younger entries
    step(1, 10'h20, 0, 32'h2000, 0, 0, 0);
    step(1, 10'h21, 1, 32'h3000, 0, 0, 0);
    step(1, 10'h22, 1, 32'h4000, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t3_mispredict", 32'(bus.mispredict), 1);
    chk("t3_redirect", bus.redirect_pc, 32'h2000);
    chk("t3_count", 32'(bus.count), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_no_upd", 32'(bus.upd_write), 0);

    // 4: alloc + correct resolve in the same cycle
    step(1, 10'h30, 1, 32'h5000, 0, 0, 0);
    step(1, 10'h31, 0, 32'h5100, 0, 0, 0);
    step(1, 10'h32, 0, 32'h5200, 1, 1, 0);
    chk("t4_count", 32'(bus.count), 2);
    chk("t4_upd_write", 32'(bus.upd_write), 1);
    chk("t4_upd_idx", 32'(bus.upd_idx), 32'h30);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t4_single_upd", 32'(bus.upd_write), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t4_drain_idx", 32'(bus.upd_idx), 32'h32);

    // 5: resolve while empty sets sticky underflow
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t5_no_upd", 32'(bus.upd_write), 0);
    chk("t5_underflow", 32'(bus.underflow_err), 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("t5_sticky", 32'(bus.underflow_err), 1);

    // 6: flush with mispredicting resolve, then async reset mid-burst
    step(1, 10'h40, 1, 32'h6000, 0, 0, 0);
    step(1, 10'h41, 1, 32'h6100, 0, 0, 0);
    step(1, 10'h42, 1, 32'h6200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t6_flush_upd", 32'(bus.upd_write), 1);
    chk("t6_flush_mis", 32'(bus.mispredict), 0);
    chk("t6_flush_count", 32'(bus.count), 0);
    step(1, 10'h50, 1, 32'h7000, 0, 0, 0);
    step(1, 10'h51, 1, 32'h7100, 0, 0, 0);
    step(1, 10'h52, 0, 32'h7200, 1, 1, 0);
    chk("t6_burst_upd", 32'(bus.upd_write), 1);
    rst = 0;
    #1;
    chk("t6_rst_upd", 32'(bus.upd_write), 0);
    chk("t6_rst_mis", 32'(bus.mispredict), 0);
    chk("t6_rst_count", 32'(bus.count), 0);
    chk("t6_rst_idx", 32'(bus.upd_idx), 0);
    chk("t6_rst_pc", bus.redirect_pc, 0);
    chk("t6_rst_uf", 32'(bus.underflow_err), 0);
    @(posedge clk); #1;
    rst = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t6_post_uf", 32'(bus.underflow_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
